// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, qualifies the start bit at mid-bit and shifts
// data in LSB first, reporting each frame as a valid or framing-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CPB   = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 rx_prev;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_prev      <= 1'b1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_prev      <= rx_s;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Only a genuine 1->0 transition arms the receiver, so a held break stays quiet.
                    if (rx_prev && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit of margin to catch the next start.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CPB=100: frames are queued as driven and
// matched against each rx_valid / rx_frame_err strobe.
module tb_uart_rx;

    localparam int CPB = 100;

    logic       clock;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_RATE  (100000000),
        .BAUD_RATE (1000000),
        .DATA_BITS (8)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         evt_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] last_good = 8'h00;
    bit         prev_strobe = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clock) begin
        exp_t e;
        if (rx_valid && rx_frame_err) chk("exclusive", 1, 0);
        if ((rx_valid || rx_frame_err) && prev_strobe) chk("pulse_width", 2, 1);
        prev_strobe <= rx_valid || rx_frame_err;
        if (rx_valid || rx_frame_err) begin
            evt_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_out", int'(rx_frame_err), 2);
            end else begin
                e = sb.pop_front();
                chk("kind_err", int'(rx_frame_err), int'(e.err));
                chk("data", int'(rx_data), int'(e.data));
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input int bl, input logic stop);
        rx = 1'b0;
        repeat (bl) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bl) @(negedge clock);
        end
        rx = stop;
        repeat (bl) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic push_good(input logic [7:0] d);
        exp_t e;
        e.err  = 1'b0;
        e.data = d;
        sb.push_back(e);
        last_good = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.err  = 1'b1;
        e.data = last_good;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int start_cyc;
        int busy_cnt;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clock);
        rst_n = 1'b1;
        repeat (5) @(negedge clock);

        chk("reset_data", int'(rx_data), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_err", int'(rx_frame_err), 0);
        chk("reset_busy", int'(rx_busy), 0);

        // 1: single byte and latency
        evt_q.delete();
        start_cyc = cyc;
        push_good(8'hA5);
        send_frame(8'hA5, CPB, 1'b1);
        repeat (20) @(negedge clock);
        wait_drain("t1_drain");
        chk("t1_pulses", evt_q.size(), 1);
        if (evt_q.size() > 0) chk("t1_latency", evt_q[0] - start_cyc, 2 + 50 + 900 + 1);

        // 2: back-to-back
        repeat (300) @(negedge clock);
        evt_q.delete();
        push_good(8'h00);
        push_good(8'hFF);
        push_good(8'h3C);
        send_frame(8'h00, CPB, 1'b1);
        send_frame(8'hFF, CPB, 1'b1);
        send_frame(8'h3C, CPB, 1'b1);
        repeat (20) @(negedge clock);
        wait_drain("t2_drain");
        chk("t2_pulses", evt_q.size(), 3);
        if (evt_q.size() == 3) begin
            chk("t2_gap01", evt_q[1] - evt_q[0], 1000);
            chk("t2_gap12", evt_q[2] - evt_q[1], 1000);
        end

        // 3: glitch rejection
        repeat (300) @(negedge clock);
        evt_q.delete();
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 20) rx = 1'b1;
            @(negedge clock);
            if (rx_busy) busy_cnt++;
        end
        chk("t3_busy_cycles", busy_cnt, 50);
        chk("t3_no_output", evt_q.size(), 0);
        chk("t3_data_kept", int'(rx_data), int'(last_good));

        // 4: framing error, then a good frame
        repeat (300) @(negedge clock);
        evt_q.delete();
        push_err();
        send_frame(8'h3C, CPB, 1'b0);
        repeat (200) @(negedge clock);
        wait_drain("t4_err_drain");
        chk("t4_err_data_kept", int'(rx_data), 8'h3C);
        push_good(8'h5A);
        send_frame(8'h5A, CPB, 1'b1);
        repeat (20) @(negedge clock);
        wait_drain("t4_drain");
        chk("t4_pulses", evt_q.size(), 2);

        // 5a: break
        repeat (300) @(negedge clock);
        evt_q.delete();
        push_err();
        rx = 1'b0;
        repeat (5000) @(negedge clock);
        rx = 1'b1;
        repeat (300) @(negedge clock);
        wait_drain("t5_break_drain");
        chk("t5_break_pulses", evt_q.size(), 1);

        // 5b: reset during bit 3 of 0xC3
        evt_q.delete();
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx = (8'hC3 >> i) & 1;
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        chk("t5_busy_before_rst", int'(rx_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", int'(rx_data), 0);
        chk("t5_rst_busy", int'(rx_busy), 0);
        chk("t5_rst_valid", int'(rx_valid), 0);
        chk("t5_rst_err", int'(rx_frame_err), 0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (10) @(negedge clock);
        rst_n = 1'b1;
        repeat (50) @(negedge clock);
        push_good(8'h81);
        send_frame(8'h81, CPB, 1'b1);
        repeat (20) @(negedge clock);
        wait_drain("t5_drain");
        chk("t5_pulses", evt_q.size(), 1);

        // 6: baud skew
        repeat (300) @(negedge clock);
        push_good(8'h96);
        send_frame(8'h96, 97, 1'b1);
        repeat (200) @(negedge clock);
        wait_drain("t6_fast_drain");
        push_good(8'h96);
        send_frame(8'h96, 103, 1'b1);
        repeat (200) @(negedge clock);
        wait_drain("t6_slow_drain");
        chk("t6_data", int'(rx_data), 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link: oversamples the asynchronous serial input, detects and validates start bits, and shifts in LSB-first data at mid-bit. It returns each byte with a one-cycle valid pulse, or flags a framing error. It sits at the pin side of the UART block, opposite the transmitter. Its output pulses feed the same downstream logic style that consumes single-cycle strobes such as `tx_send`.

## Interface
- `CLK_RATE`, default 100000000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5–8.
- `clock`, input, 1 bit: sole clock. All logic is rising-edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `rx`, input, 1 bit: asynchronous serial line. Idle level is 1.
- `rx_data`, output, `DATA_BITS` bits: last correctly framed word. Bit 0 is the first bit received.
- `rx_valid`, output, 1 bit: one-cycle pulse when `rx_data` has been updated.
- `rx_frame_err`, output, 1 bit: one-cycle pulse when the stop bit was sampled as 0.
- `rx_busy`, output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Constants**
  - CPB = `CLK_RATE/BAUD_RATE` (integer division, truncated). HALF = CPB/2.
  - Baud counter width is `$clog2(CPB)`. It counts 0..CPB-1 and resets to 0 on every state change.
- **Input conditioning**
  - `rx` passes through a 2-FF synchronizer, giving `rx_s`. The synchronizer flops reset to 1.
  - `rx_prev` holds the previous `rx_s`.
  - A falling edge is `rx_prev==1 && rx_s==0`.
- **IDLE**
  - Counter held at 0.
  - On a falling edge, go to START.
- **START**
  - When the counter reaches HALF-1, sample `rx_s`.
  - If 0: go to DATA with bit index 0.
  - If 1: false start. Return to IDLE with no output.
- **DATA**
  - When the counter reaches CPB-1, shift `rx_s` into the shift register (LSB first) and increment the bit index.
  - After the sample with index `DATA_BITS-1`, go to STOP.
- **STOP**
  - When the counter reaches CPB-1, sample `rx_s` and go to IDLE.
  - If 1: load `rx_data` from the shift register and pulse `rx_valid`.
  - If 0: pulse `rx_frame_err`. `rx_data` is unchanged.
- **Re-arm**
  - The return to IDLE happens at mid-stop-bit, so a start bit immediately following is caught.
  - IDLE needs a fresh falling edge. A line held low (break) therefore yields exactly one `rx_frame_err`, and nothing further until the line returns high and falls again.
- **Exclusivity**
  - `rx_valid` and `rx_frame_err` are never high together.
  - Neither is ever high for more than one cycle.

## Timing
- **Reset values**
  - FSM = IDLE, counters = 0, shift register = 0.
  - `rx_data` = 0, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - Synchronizer and `rx_prev` = 1.
- **Reset mid-frame**
  - Asserting `rst_n` during a frame aborts it immediately. No pulse is emitted.
  - After release, the block waits for a new falling edge.
- **Latency** (edge k = the first rising edge at which `rx` is sampled 0 by synchronizer stage 1)
  - `rx_s` falls after edge k+1.
  - The FSM enters START after edge k+2.
  - Start is sampled at edge k+2+HALF.
  - Data bit i is sampled at edge k+2+HALF+(i+1)·CPB.
  - Stop is sampled at edge k+2+HALF+(DATA_BITS+1)·CPB.
  - `rx_valid`/`rx_frame_err` are registered on the stop-sample edge, so they are high for the following cycle.
- **Tolerance**
  - Mid-bit sampling tolerates up to ±(HALF−3)/((DATA_BITS+1)·CPB) relative baud mismatch.

## Structure
- **Package `uart_pkg`**
  - State enum: IDLE, START, DATA, STOP.
  - Function `clks_per_bit(clk_rate, baud)`.
  - Shared with the transmitter.
- **Sub-module `sync_2ff`**
  - Single-bit, parameterised reset value.
  - Reusable for the button input path.
- **Top module**
  - FSM, baud counter, bit index, shift register and output registers in `uart_rx`.

## Test plan
All scenarios use `CLK_RATE`=100000000 and `BAUD_RATE`=1000000, so CPB=100 and HALF=50.

1. **Single byte**: send 0xA5 (8N1) after reset → one `rx_valid` pulse, `rx_data`=0xA5. The pulse occurs exactly 2+50+9·100 edges after the first low sample, +1 cycle. `rx_frame_err` stays 0.
2. **Back-to-back bytes**: send 0x00, 0xFF, 0x3C with no idle gap between frames → three `rx_valid` pulses, 1000 cycles apart, with the correct values in order.
3. **Glitch rejection**: drive `rx` low for 20 cycles, then high → `rx_busy` pulses for about 50 cycles. No `rx_valid` and no `rx_frame_err`. `rx_data` is unchanged.
4. **Framing error**: send 0x3C with the stop bit forced to 0 → one `rx_frame_err` pulse and no `rx_valid`. `rx_data` keeps its prior value. A following valid 0x5A frame is received correctly.
5. **Break and reset mid-frame**
   - Hold `rx` low for 5000 cycles → exactly one `rx_frame_err`.
   - Separately, assert `rst_n`=0 during bit 3 of 0xC3, release, then send 0x81 → outputs go to reset values immediately. Only 0x81 is reported.
6. **Baud skew**: send 0x96 at bit periods of 97 and 103 cycles → received correctly in both cases.
